// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, mem_addr, mem_wdata, mem_wen, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, mem_addr, mem_wdata, mem_wen, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter onto a single memory port
// MEM_ARB_CPU_PRIORITY_EN: when defined, port 0 wins every tie (fixed priority).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e            state_q, state_d;
  logic              lat_port_q, lat_port_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              last_gnt_q, last_gnt_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              win_port;

  always_comb begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
    win_port = ~bus_io.req0;
`else
    // On a tie the port that was not granted last goes next.
    win_port = (bus_io.req0 && bus_io.req1) ? ~last_gnt_q : bus_io.req1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_port_q  <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      last_gnt_q  <= 1'b1;
      wait_cnt_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      lat_port_q  <= lat_port_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      last_gnt_q  <= last_gnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lat_port_d     = lat_port_q;
    lat_we_d       = lat_we_q;
    lat_addr_d     = lat_addr_q;
    lat_wdata_d    = lat_wdata_q;
    last_gnt_d     = last_gnt_q;
    wait_cnt_d     = wait_cnt_q;
    bus_io.gnt0    = 1'b0;
    bus_io.gnt1    = 1'b0;
    bus_io.rvalid0 = 1'b0;
    bus_io.rvalid1 = 1'b0;
    bus_io.mem_wen = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_io.req0 || bus_io.req1) begin
          lat_port_d  = win_port;
          lat_we_d    = win_port ? bus_io.we1    : bus_io.we0;
          lat_addr_d  = win_port ? bus_io.addr1  : bus_io.addr0;
          lat_wdata_d = win_port ? bus_io.wdata1 : bus_io.wdata0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        bus_io.gnt0    = ~lat_port_q;
        bus_io.gnt1    = lat_port_q;
        bus_io.mem_wen = lat_we_q;
        last_gnt_d     = lat_port_q;
        if (lat_we_q) begin
          state_d = IDLE;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = 3'd1;
        end
      end
      WAIT: begin
        if (wait_cnt_q == RD_LAT_C) begin
          bus_io.rvalid0 = ~lat_port_q;
          bus_io.rvalid1 = lat_port_q;
          state_d        = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data come straight from the latches so they stay stable through WAIT.
  assign bus_io.mem_addr  = lat_addr_q;
  assign bus_io.mem_wdata = lat_wdata_q;
  assign bus_io.rdata     = bus_io.mem_rdata;
  assign bus_io.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_port_arbiter;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus_io(if_a)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .bus_io(if_b)
  );

  assign if_a.req0 = req0;   assign if_b.req0 = req0;
  assign if_a.we0 = we0;     assign if_b.we0 = we0;
  assign if_a.addr0 = addr0; assign if_b.addr0 = addr0;
  assign if_a.wdata0 = wdata0; assign if_b.wdata0 = wdata0;
  assign if_a.req1 = req1;   assign if_b.req1 = req1;
  assign if_a.we1 = we1;     assign if_b.we1 = we1;
  assign if_a.addr1 = addr1; assign if_b.addr1 = addr1;
  assign if_a.wdata1 = wdata1; assign if_b.wdata1 = wdata1;

  // Instance A: small writable memory, preloaded on reset; word 8 (0x20) = 0x12345678, others = index.
  logic [31:0] mem_a [0:63];
  assign if_a.mem_rdata = mem_a[if_a.mem_addr[7:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= (i == 8) ? 32'h1234_5678 : 32'(i);
    end else if (if_a.mem_wen) begin
      mem_a[if_a.mem_addr[7:2]] <= if_a.mem_wdata;
    end
  end

  // Instance B: read-only pattern memory.
  assign if_b.mem_rdata = if_b.mem_addr ^ 32'h5A5A_0000;

  // Flag order: gnt0, gnt1, rvalid0, rvalid1, mem_wen, busy
  logic [5:0] fl_a, fl_b;
  assign fl_a = {if_a.gnt0, if_a.gnt1, if_a.rvalid0, if_a.rvalid1, if_a.mem_wen, if_a.busy};
  assign fl_b = {if_b.gnt0, if_b.gnt1, if_b.rvalid0, if_b.rvalid1, if_b.mem_wen, if_b.busy};

  typedef struct {
    logic        rst;
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic [5:0]  fl;
    logic [31:0] maddr, mwdata;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic q0, input logic w0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic q1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [5:0] fl, input logic [31:0] ma,
                              input logic [31:0] md, input logic crd, input logic [31:0] rd);
    vec_t v;
    v.rst = r; v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.fl = fl; v.maddr = ma; v.mwdata = md; v.chk_rd = crd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  vec_t tbl [14];
  int   ngr;
  int   exp_port;
  int   last_port;
  bit   saw_rv;

  initial begin
    tbl[0]  = mk(0, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h00, 32'h0,         0, 32'h0);
    tbl[1]  = mk(1, 1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,         6'b100011, 32'h10, 32'hDEADBEEF,  0, 32'h0);
    tbl[2]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h10, 32'hDEADBEEF,  0, 32'h0);
    tbl[3]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h10, 32'hDEADBEEF,  0, 32'h0);
    tbl[4]  = mk(1, 0,0,32'h0,32'h0,         1,0,32'h20,32'h0,        6'b010001, 32'h20, 32'h0,         0, 32'h0);
    tbl[5]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000101, 32'h20, 32'h0,         1, 32'h12345678);
    tbl[6]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h20, 32'h0,         0, 32'h0);
    tbl[7]  = mk(1, 1,0,32'h10,32'h0,        0,0,32'h0,32'h0,         6'b100001, 32'h10, 32'h0,         0, 32'h0);
    tbl[8]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b001001, 32'h10, 32'h0,         1, 32'hDEADBEEF);
    tbl[9]  = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h10, 32'h0,         0, 32'h0);
    tbl[10] = mk(1, 0,0,32'h0,32'h0,         1,1,32'h24,32'hCAFEF00D, 6'b010011, 32'h24, 32'hCAFEF00D,  0, 32'h0);
    tbl[11] = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b000000, 32'h24, 32'hCAFEF00D,  0, 32'h0);
    tbl[12] = mk(1, 1,0,32'h24,32'h0,        0,0,32'h0,32'h0,         6'b100001, 32'h24, 32'h0,         0, 32'h0);
    tbl[13] = mk(1, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         6'b001001, 32'h24, 32'h0,         1, 32'hCAFEF00D);

    #2;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      req0 = tbl[i].req0; we0 = tbl[i].we0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      tick();
      chk($sformatf("vec%0d_flags", i), {26'd0, fl_a}, {26'd0, tbl[i].fl});
      chk($sformatf("vec%0d_mem_addr", i), if_a.mem_addr, tbl[i].maddr);
      chk($sformatf("vec%0d_mem_wdata", i), if_a.mem_wdata, tbl[i].mwdata);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), if_a.rdata, tbl[i].rd);
    end

    // Both ports reading back-to-back with requests held; reset restores last_gnt=1.
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req0 = 1'b1; addr0 = 32'h44;
    req1 = 1'b1; addr1 = 32'h48;
    ngr = 0;
    last_port = -1;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      tick();
      if (if_a.gnt0 && if_a.gnt1) chk("dual_gnt", 32'd1, 32'd0);
      if (if_a.rvalid0 && if_a.rvalid1) chk("dual_rvalid", 32'd1, 32'd0);
      if (if_a.rvalid0) begin
        chk("rr_rvalid0_port", 32'(last_port), 32'd0);
        chk("rr_rdata0", if_a.rdata, 32'h11);
      end
      if (if_a.rvalid1) begin
        chk("rr_rvalid1_port", 32'(last_port), 32'd1);
        chk("rr_rdata1", if_a.rdata, 32'h12);
      end
      if (if_a.gnt0 || if_a.gnt1) begin
        exp_port = PRIO ? 0 : (ngr % 2);
        last_port = if_a.gnt1 ? 1 : 0;
        chk($sformatf("grant%0d_port", ngr), 32'(last_port), 32'(exp_port));
        ngr++;
      end
    end
    chk("grant_count", 32'(ngr), 32'd6);
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();

    // RD_LAT=3: reset asserted in the second WAIT cycle drops the read.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req0 = 1'b1; addr0 = 32'h40;
    tick();
    chk("t5_issue_flags", {26'd0, fl_b}, {26'd0, 6'b100001});
    chk("t5_issue_addr", if_b.mem_addr, 32'h40);
    req0 = 1'b0;
    tick();
    chk("t5_wait1_flags", {26'd0, fl_b}, {26'd0, 6'b000001});
    tick();
    chk("t5_wait2_flags", {26'd0, fl_b}, {26'd0, 6'b000001});
    chk("t5_wait2_addr", if_b.mem_addr, 32'h40);
    rst = 1'b0;
    tick();
    chk("t5_rst_flags", {26'd0, fl_b}, 32'd0);
    chk("t5_rst_addr", if_b.mem_addr, 32'd0);
    chk("t5_rst_wdata", if_b.mem_wdata, 32'd0);
    rst = 1'b1;
    saw_rv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_b.rvalid0 || if_b.busy) saw_rv = 1'b1;
    end
    chk("t5_no_rvalid_after_rst", {31'd0, saw_rv}, 32'd0);
    req1 = 1'b1; addr1 = 32'h20;
    tick();
    chk("t5_gnt1_flags", {26'd0, fl_b}, {26'd0, 6'b010001});
    req1 = 1'b0;
    tick();
    chk("t5_r1_wait1", {26'd0, fl_b}, {26'd0, 6'b000001});
    tick();
    chk("t5_r1_wait2", {26'd0, fl_b}, {26'd0, 6'b000001});
    tick();
    chk("t5_r1_wait3", {26'd0, fl_b}, {26'd0, 6'b000101});
    chk("t5_r1_rdata", if_b.rdata, 32'h5A5A_0020);
    tick();
    chk("t5_r1_idle", {26'd0, fl_b}, 32'd0);

    // req1 arrives while a port 0 read is waiting.
    req0 = 1'b1; addr0 = 32'h40;
    tick();
    chk("t6_issue0", {26'd0, fl_b}, {26'd0, 6'b100001});
    req0 = 1'b0;
    tick();
    chk("t6_wait1", {26'd0, fl_b}, {26'd0, 6'b000001});
    chk("t6_wait1_addr", if_b.mem_addr, 32'h40);
    req1 = 1'b1; addr1 = 32'h20;
    tick();
    chk("t6_wait2", {26'd0, fl_b}, {26'd0, 6'b000001});
    chk("t6_wait2_addr", if_b.mem_addr, 32'h40);
    tick();
    chk("t6_wait3", {26'd0, fl_b}, {26'd0, 6'b001001});
    chk("t6_wait3_addr", if_b.mem_addr, 32'h40);
    chk("t6_rdata0", if_b.rdata, 32'h5A5A_0040);
    tick();
    chk("t6_idle", {26'd0, fl_b}, 32'd0);
    tick();
    chk("t6_gnt1", {26'd0, fl_b}, {26'd0, 6'b010001});
    chk("t6_gnt1_addr", if_b.mem_addr, 32'h20);
    idle_inputs();
    for (int c = 0; c < 6; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory_integrated port between two requesters.
- Port 0 is the CPU fetch/load/store path. Port 1 is a secondary master (DMA/debug loader).
- Sits between the requesters and the memory's addressVirt/dataInVirt/wEnVirt/dataOutVirt.
- Provides a req/gnt/rvalid handshake with round-robin arbitration.
- Transactions are non-pipelined: one transaction is in flight at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from the memory issue cycle to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req0  in  1  port 0 request
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 accepted; single-cycle pulse
- rvalid0  out  1  port 0 read data valid; single-cycle pulse
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
- rdata  out  DATA_W  read data, shared by both ports; qualified by rvalid0/rvalid1
- mem_addr  out  ADDR_W  to memory addressVirt
- mem_wdata  out  DATA_W  to memory dataInVirt
- mem_wen  out  1  to memory wEnVirt
- mem_rdata  in  DATA_W  from memory dataOutVirt
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT.
  - Registers: state, lat_port, lat_we, lat_addr, lat_wdata, last_gnt, wait_cnt (3 bits).
- Reset (rst=0 at a clk edge):
  - state=IDLE, lat_*=0, last_gnt=1, wait_cnt=0.
  - Every output is 0: gnt*, rvalid*, mem_wen, busy, mem_addr, mem_wdata. rdata follows mem_rdata.
  - A read in flight is dropped; no rvalid is produced.
- IDLE:
  - Samples req0/req1 each cycle.
  - With any request pending, the next edge latches the winner's we/addr/wdata into lat_* and moves to ISSUE.
  - Arbitration: a single requester wins. If both request, the winner is the port != last_gnt (round-robin).
- ISSUE (exactly 1 cycle):
  - gnt[lat_port]=1.
  - mem_addr=lat_addr, mem_wdata=lat_wdata, mem_wen=lat_we.
  - last_gnt<=lat_port.
  - Write: next state IDLE.
  - Read: next state WAIT, wait_cnt<=1.
- WAIT:
  - mem_addr is held at lat_addr; mem_wen=0.
  - When wait_cnt==RD_LAT: rvalid[lat_port]=1, rdata=mem_rdata, next state IDLE.
  - Otherwise: wait_cnt increments.
- Outside ISSUE: mem_wen=0 and gnt*=0.
  - mem_addr/mem_wdata always reflect lat_addr/lat_wdata, so the address is stable through WAIT.
- Latency from req high in IDLE:
  - gnt in the next cycle.
  - Write committed at the end of the ISSUE cycle.
  - rvalid RD_LAT cycles after ISSUE.
- Throughput:
  - Write: 2 cycles per transaction (ISSUE + IDLE).
  - Read: RD_LAT+2 cycles per transaction.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Deassert req, or present the next request, in the cycle after gnt.
  - req still high in the next IDLE is treated as a new transaction.
- Requests arriving during ISSUE/WAIT are not sampled until IDLE. Nothing is lost provided req is held.
- Never: both gnt bits high, both rvalid bits high, or mem_wen in IDLE/WAIT.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. Port 0 always wins a tie. last_gnt is still updated but ignored. Port 1 may starve.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Reset, then req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF.
   -> gnt0 in cycle 2; mem_wen=1 for exactly 1 cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF; busy 1 cycle; no rvalid.
2. RD_LAT=1; port 1 reads addr 0x20 while memory model returns 0x12345678.
   -> gnt1 pulse, then rvalid1 one cycle later with rdata=0x12345678; rvalid0 stays 0.
3. req0 and req1 held high continuously, both reading, over 6 transactions.
   -> grant order 0,1,0,1,0,1 (reset last_gnt=1); never two consecutive grants to one port.
4. Same stimulus with MEM_ARB_CPU_PRIORITY_EN defined.
   -> all 6 grants to port 0; gnt1 never asserts while req0 is held.
5. RD_LAT=3; port 0 read of 0x40, rst pulled low in the second WAIT cycle.
   -> next cycle all outputs 0, state IDLE, no rvalid0; a new req1 afterward is granted normally.
6. req1 rises during a port 0 read's WAIT.
   -> gnt1 only in the cycle after the return to IDLE; mem_addr holds 0x40 throughout WAIT.
